// File: rtl/overlap_window_addr_gen_if.sv
// ---------------------------------------------------------------------------
// overlap_window_addr_gen_if
//   Groups the control inputs and the address/flag outputs of the overlapped
//   window address generator.
//   master : sample source and window consumer. Drives flush, enqueue,
//            dequeue and hop. Observes the addresses and the flags.
//   slave  : the generator itself.
//   Signals:
//     flush      : synchronous clear of pointers and flags
//     enqueue    : source requests a sample write
//     dequeue    : consumer requests a sample read
//     hop        : window advance in samples, sampled at each window's first read
//     write_addr : RAM write address
//     read_addr  : RAM read address
//     write      : RAM write enable
//     read       : RAM read enable
//     win_idx    : position of the current sample inside the window
//     first      : asserted on the read of window index 0
//     last       : asserted on the read of window index WINLEN-1
//     full       : all DEPTH slots hold retained samples
//     empty      : no unread sample for the current window position
//     fill_level : number of retained samples, overlap included
//     overflow   : sticky flag, set by an enqueue while full
// ---------------------------------------------------------------------------
interface overlap_window_addr_gen_if #(
    parameter int ADDRWIDTH = 12,
    parameter int WLOG2     = 11
) ();
    logic                 flush;
    logic                 enqueue;
    logic                 dequeue;
    logic [WLOG2:0]       hop;
    logic [ADDRWIDTH-1:0] write_addr;
    logic [ADDRWIDTH-1:0] read_addr;
    logic                 write;
    logic                 read;
    logic [WLOG2-1:0]     win_idx;
    logic                 first;
    logic                 last;
    logic                 full;
    logic                 empty;
    logic [ADDRWIDTH:0]   fill_level;
    logic                 overflow;

    modport master (
        output flush, enqueue, dequeue, hop,
        input  write_addr, read_addr, write, read, win_idx, first, last,
               full, empty, fill_level, overflow
    );

    modport slave (
        input  flush, enqueue, dequeue, hop,
        output write_addr, read_addr, write, read, win_idx, first, last,
               full, empty, fill_level, overflow
    );
endinterface

// File: rtl/overlap_window_addr_gen.sv
// ---------------------------------------------------------------------------
// overlap_window_addr_gen
//   Address and flag generator for a circular sample RAM. The RAM feeds
//   overlapped analysis windows to an STFT front end, and the RAM itself is
//   external to this block.
//   - Samples are written sequentially.
//   - Each window reads WINLEN consecutive samples, starting at win_base.
//   - At the end of a window, win_base advances by the hop that was latched
//     at that window's first read. A hop smaller than WINLEN gives overlap.
//   Ports:
//     clock   : rising-edge clock
//     reset_n : synchronous, active-low reset
//     bus     : overlap_window_addr_gen_if.slave (controls, addresses, flags)
// ---------------------------------------------------------------------------
module overlap_window_addr_gen #(
    parameter int ADDRWIDTH = 12,
    parameter int WLOG2     = 11
) (
    input  logic                       clock,
    input  logic                       reset_n,
    overlap_window_addr_gen_if.slave   bus
);
    localparam int PW = ADDRWIDTH + 1;   // pointer width: extra MSB separates full from empty
    localparam int HW = WLOG2 + 1;       // hop width: can hold WINLEN itself

    localparam logic [PW-1:0]    DEPTH_P  = {1'b1, {ADDRWIDTH{1'b0}}};
    localparam logic [HW-1:0]    WINLEN_P = {1'b1, {WLOG2{1'b0}}};
    localparam logic [WLOG2-1:0] IDX_LAST = '1;

    logic [PW-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]    win_base_q, win_base_d;
    logic [WLOG2-1:0] idx_q,      idx_d;
    logic [HW-1:0]    hop_q,      hop_d;
    logic             overflow_q, overflow_d;

    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    fill;
    logic             full_w;
    logic             empty_w;
    logic             write_w;
    logic             read_w;
    logic             at_first;
    logic             at_last;
    logic [HW-1:0]    hop_eff;

    // Flags are built from the current state only. A space-freeing last
    // read therefore does not unblock a write in the same cycle.
    always_comb begin
        rd_ptr   = win_base_q + PW'(idx_q);
        fill     = wr_ptr_q - win_base_q;
        full_w   = (fill == DEPTH_P);
        empty_w  = (wr_ptr_q == rd_ptr);
        write_w  = bus.enqueue && !full_w;
        read_w   = bus.dequeue && !empty_w;
        at_first = (idx_q == '0);
        at_last  = (idx_q == IDX_LAST);
        // A hop of zero or one larger than a window would skip or stall data,
        // so those values fall back to a non-overlapped advance.
        hop_eff  = ((bus.hop == '0) || (bus.hop > WINLEN_P)) ? WINLEN_P : bus.hop;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        win_base_d = win_base_q;
        idx_d      = idx_q;
        hop_d      = hop_q;
        overflow_d = overflow_q;

        if (write_w) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        if (bus.enqueue && full_w) begin
            overflow_d = 1'b1;
        end

        if (read_w) begin
            // The hop is latched at the first read, so a later change on the
            // hop input only affects the next window.
            if (at_first) begin
                hop_d = hop_eff;
            end
            if (at_last) begin
                idx_d      = '0;
                win_base_d = win_base_q + PW'(hop_q);
            end else begin
                idx_d = idx_q + WLOG2'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || bus.flush) begin
            wr_ptr_q   <= '0;
            win_base_q <= '0;
            idx_q      <= '0;
            hop_q      <= WINLEN_P;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            win_base_q <= win_base_d;
            idx_q      <= idx_d;
            hop_q      <= hop_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.write_addr = wr_ptr_q[ADDRWIDTH-1:0];
    assign bus.read_addr  = rd_ptr[ADDRWIDTH-1:0];
    assign bus.write      = write_w;
    assign bus.read       = read_w;
    assign bus.win_idx    = idx_q;
    assign bus.first      = read_w && at_first;
    assign bus.last       = read_w && at_last;
    assign bus.full       = full_w;
    assign bus.empty      = empty_w;
    assign bus.fill_level = fill;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_overlap_window_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_overlap_window_addr_gen
//   Directed bench for overlap_window_addr_gen with DEPTH=16 and WINLEN=8.
//   The stimulus pushes the expected read/write transaction for each cycle.
//   A monitor compares the DUT against that transaction whenever the DUT
//   asserts read or write. Status outputs are compared directly after each
//   step.
// ---------------------------------------------------------------------------
module tb_overlap_window_addr_gen;
    localparam int AW = 4;
    localparam int WL = 3;

    logic clock;
    logic reset_n;

    overlap_window_addr_gen_if #(.ADDRWIDTH(AW), .WLOG2(WL)) bus ();

    overlap_window_addr_gen #(.ADDRWIDTH(AW), .WLOG2(WL)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int tnum;
        bit rd;
        bit wr;
        int raddr;
        int waddr;
        int idx;
        bit first;
        bit last;
    } txn_t;

    txn_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pushed = 0;

    task automatic push(input bit rd, input bit wr, input int ra, input int wa,
                        input int idx, input bit f, input bit l);
        txn_t t;
        t.tnum  = n_pushed;
        t.rd    = rd;
        t.wr    = wr;
        t.raddr = ra;
        t.waddr = wa;
        t.idx   = idx;
        t.first = f;
        t.last  = l;
        exp_q.push_back(t);
        n_pushed++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_status(input string tag, input int wa, input int ra, input int widx,
                              input int fill, input int emp, input int ful, input int ovf);
        chk({tag, "_write_addr"}, int'(bus.write_addr), wa);
        chk({tag, "_read_addr"},  int'(bus.read_addr),  ra);
        chk({tag, "_win_idx"},    int'(bus.win_idx),    widx);
        chk({tag, "_fill_level"}, int'(bus.fill_level), fill);
        chk({tag, "_empty"},      int'(bus.empty),      emp);
        chk({tag, "_full"},       int'(bus.full),       ful);
        chk({tag, "_overflow"},   int'(bus.overflow),   ovf);
    endtask

    // Inputs change 1 time unit after a rising edge and are held for one
    // full cycle. The monitor samples on the falling edge in between.
    task automatic step(input bit e, input bit d, input int h);
        bus.enqueue = e;
        bus.dequeue = d;
        bus.hop     = (WL+1)'(h);
        @(posedge clock);
        #1;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        step(1'b0, 1'b0, 8);
        bus.flush = 1'b0;
    endtask

    // Monitor: one compare per DUT transaction.
    always @(negedge clock) begin
        if (bus.read || bus.write) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_txn: got read=%0b write=%0b raddr=%0d waddr=%0d required none",
                         bus.read, bus.write, bus.read_addr, bus.write_addr);
            end else begin
                txn_t e;
                bit   ok;
                e  = exp_q.pop_front();
                ok = (bus.read == e.rd) && (bus.write == e.wr);
                if (e.rd) begin
                    ok = ok && (int'(bus.read_addr) == e.raddr) && (int'(bus.win_idx) == e.idx)
                            && (bus.first == e.first) && (bus.last == e.last);
                end
                if (e.wr) begin
                    ok = ok && (int'(bus.write_addr) == e.waddr);
                end
                n_checks++;
                if (!ok) begin
                    n_errors++;
                    $display("FAIL txn%0d: got rd=%0b wr=%0b raddr=%0d waddr=%0d idx=%0d first=%0b last=%0b required rd=%0b wr=%0b raddr=%0d waddr=%0d idx=%0d first=%0b last=%0b",
                             e.tnum, bus.read, bus.write, bus.read_addr, bus.write_addr, bus.win_idx,
                             bus.first, bus.last, e.rd, e.wr, e.raddr, e.waddr, e.idx, e.first, e.last);
                end
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        bus.flush   = 1'b0;
        bus.enqueue = 1'b0;
        bus.dequeue = 1'b0;
        bus.hop     = '0;
        @(posedge clock);
        #1;

        // 1: reset state
        step(1'b0, 1'b0, 8);
        step(1'b0, 1'b0, 8);
        reset_n = 1'b1;
        chk_status("t1_reset", 0, 0, 0, 0, 1, 0, 0);

        // 2: hop=4, write 8 then read one window, then a partial window
        for (int i = 0; i < 8; i++) begin
            push(1'b0, 1'b1, 0, i, 0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 4);
        end
        chk("t2_fill_after_wr", int'(bus.fill_level), 8);
        for (int i = 0; i < 8; i++) begin
            push(1'b1, 1'b0, i, 0, i, i == 0, i == 7);
            step(1'b0, 1'b1, 4);
        end
        chk("t2_fill_after_win", int'(bus.fill_level), 4);
        chk("t2_raddr_after_win", int'(bus.read_addr), 4);
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 1'b0, 4 + i, 0, i, i == 0, 1'b0);
            step(1'b0, 1'b1, 4);
        end
        step(1'b0, 1'b1, 4);      // dequeue while empty: must not read
        chk_status("t2_empty", 8, 8, 4, 4, 1, 0, 0);

        // 1b: reset in mid-window
        reset_n = 1'b0;
        step(1'b0, 1'b0, 4);
        chk_status("t1_midwin_reset", 0, 0, 0, 0, 1, 0, 0);
        reset_n = 1'b1;

        // 3: fill to full, then overflow
        for (int i = 0; i < 16; i++) begin
            push(1'b0, 1'b1, 0, i, 0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 8);
        end
        chk_status("t3_full", 0, 0, 0, 16, 0, 1, 0);
        step(1'b1, 1'b0, 8);      // 17th enqueue is dropped
        chk_status("t3_ovf", 0, 0, 0, 16, 0, 1, 1);
        push(1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8);
        chk("t3_ovf_sticky", int'(bus.overflow), 1);
        do_flush();
        chk_status("t3_flush", 0, 0, 0, 0, 1, 0, 0);

        // 4: hop=8, streaming write/read across six windows with wrap
        push(1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8);
        for (int k = 0; k < 48; k++) begin
            push(1'b1, 1'b1, k % 16, (k + 1) % 16, k % 8, (k % 8) == 0, (k % 8) == 7);
            step(1'b1, 1'b1, 8);
            chk($sformatf("t4_fill_%0d", k), int'(bus.fill_level), k + 2 - 8 * ((k + 1) / 8));
        end
        chk_status("t4_end", 1, 0, 0, 1, 0, 0, 0);

        // 5: full, last read together with enqueue
        do_flush();
        for (int i = 0; i < 16; i++) begin
            push(1'b0, 1'b1, 0, i, 0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 4);
        end
        for (int i = 0; i < 7; i++) begin
            push(1'b1, 1'b0, i, 0, i, i == 0, 1'b0);
            step(1'b0, 1'b1, 4);
        end
        chk("t5_full_before", int'(bus.full), 1);
        push(1'b1, 1'b0, 7, 0, 7, 1'b0, 1'b1);
        step(1'b1, 1'b1, 4);
        chk_status("t5_after", 0, 4, 0, 12, 0, 0, 1);

        // 6: hop change mid-window, then hop=2, hop=0, hop=9
        do_flush();
        for (int i = 0; i < 16; i++) begin
            push(1'b0, 1'b1, 0, i, 0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 4);
        end
        for (int i = 0; i < 8; i++) begin
            push(1'b1, 1'b0, i, 0, i, i == 0, i == 7);
            step(1'b0, 1'b1, (i < 3) ? 4 : 2);
        end
        chk_status("t6_hop4", 0, 4, 0, 12, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            push(1'b1, 1'b0, 4 + i, 0, i, i == 0, i == 7);
            step(1'b0, 1'b1, 2);
        end
        chk_status("t6_hop2", 0, 6, 0, 10, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            push(1'b0, 1'b1, 0, i, 0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 2);
        end
        chk("t6_full_refill", int'(bus.full), 1);
        for (int i = 0; i < 8; i++) begin
            push(1'b1, 1'b0, 6 + i, 0, i, i == 0, i == 7);
            step(1'b0, 1'b1, 0);
        end
        chk_status("t6_hop0", 6, 14, 0, 8, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            push(1'b1, 1'b0, (14 + i) % 16, 0, i, i == 0, i == 7);
            step(1'b0, 1'b1, 9);
        end
        chk_status("t6_hop9", 6, 6, 0, 0, 1, 0, 0);

        step(1'b0, 1'b0, 8);
        step(1'b0, 1'b0, 8);
        chk("sb_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
